// File: rtl/fpmul_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fpmul_pkg : shared widths and decoded-operand type for the FP unpacker  |
// | Revision  : 1.0                                                          |
// +-------------------------------------------------------------------------+
package fpmul_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = 24;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int EXP_BIAS = 127;

  typedef struct packed {
    logic             nan;
    logic             inf;
    logic             zero;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } operand_t;
endpackage
`default_nettype wire

// File: rtl/fpmul_unpack_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fpmul_unpack_if : operand-in / unpacked-out handshake bundle            |
// | Revision        : 1.0                                                    |
// +-------------------------------------------------------------------------+
interface fpmul_unpack_if;
  import fpmul_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      FP_A;
  logic [31:0]      FP_B;
  logic             out_valid;
  logic             out_ready;
  logic             SIGN_out;
  logic [EXP_W-1:0] EXP_A;
  logic [EXP_W-1:0] EXP_B;
  logic [SIG_W-1:0] SIG_A;
  logic [SIG_W-1:0] SIG_B;
  logic             isINF;
  logic             isNaN;
  logic             isZ_tab;

  modport slave (
    input  in_valid, FP_A, FP_B, out_ready,
    output in_ready, out_valid, SIGN_out, EXP_A, EXP_B, SIG_A, SIG_B,
           isINF, isNaN, isZ_tab
  );

  modport master (
    output in_valid, FP_A, FP_B, out_ready,
    input  in_ready, out_valid, SIGN_out, EXP_A, EXP_B, SIG_A, SIG_B,
           isINF, isNaN, isZ_tab
  );
endinterface
`default_nettype wire

// File: rtl/fpmul_classify.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fpmul_classify : decode one IEEE-754 single (sign excluded) into class, |
// |                  exponent and significand. Macro: FPMUL_UNPACK_DENORM_EN |
// | Revision       : 1.0                                                     |
// +-------------------------------------------------------------------------+
module fpmul_classify
  import fpmul_pkg::*;
(
  input  logic [EXP_W+FRAC_W-1:0] op_i,
  output logic                    isNaN_o,
  output logic                    isINF_o,
  output logic                    isZero_o,
  output logic [EXP_W-1:0]        EXP_o,
  output logic [SIG_W-1:0]        SIG_o
);
  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;
  logic              frac_nz;

  assign exp_f   = op_i[EXP_W+FRAC_W-1:FRAC_W];
  assign frac_f  = op_i[FRAC_W-1:0];
  assign frac_nz = |frac_f;

  always_comb begin
    isNaN_o  = 1'b0;
    isINF_o  = 1'b0;
    isZero_o = 1'b0;
    EXP_o    = exp_f;
    SIG_o    = {1'b1, frac_f};
    if (exp_f == EXP_MAX) begin
      isNaN_o = frac_nz;
      isINF_o = ~frac_nz;
    end else if (exp_f == '0) begin
      if (!frac_nz) begin
        isZero_o = 1'b1;
        SIG_o    = '0;
      end else begin
`ifdef FPMUL_UNPACK_DENORM_EN
        // Denormals carry the effective exponent 1 with no hidden bit.
        EXP_o = EXP_W'(1);
        SIG_o = {1'b0, frac_f};
`else
        isZero_o = 1'b1;
        SIG_o    = '0;
`endif
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/fpmul_unpack.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fpmul_unpack : 2-stage operand unpacker in front of an FP multiplier.   |
// |                Optional denormal support: FPMUL_UNPACK_DENORM_EN        |
// | Revision     : 1.0                                                       |
// +-------------------------------------------------------------------------+
module fpmul_unpack
  import fpmul_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  fpmul_unpack_if.slave        bus
);
  logic        adv1, adv2;
  logic        v1_q, v1_d;
  logic [31:0] a1_q, a1_d, b1_q, b1_d;
  logic        v2_q, v2_d;
  logic        sign_q, sign_d;
  logic        nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;
  logic [EXP_W-1:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d;
  logic [SIG_W-1:0] sig_a_q, sig_a_d, sig_b_q, sig_b_d;
  operand_t    op_a, op_b;
  logic        prod_nan;

  fpmul_classify u_cls_a (
    .op_i(a1_q[30:0]), .isNaN_o(op_a.nan), .isINF_o(op_a.inf),
    .isZero_o(op_a.zero), .EXP_o(op_a.exp), .SIG_o(op_a.sig)
  );

  fpmul_classify u_cls_b (
    .op_i(b1_q[30:0]), .isNaN_o(op_b.nan), .isINF_o(op_b.inf),
    .isZero_o(op_b.zero), .EXP_o(op_b.exp), .SIG_o(op_b.sig)
  );

  assign prod_nan = op_a.nan | op_b.nan | (op_a.inf & op_b.zero) | (op_a.zero & op_b.inf);

  // Each stage may advance when empty or when the stage after it drains.
  assign adv2 = ~v2_q | bus.out_ready;
  assign adv1 = ~v1_q | adv2;

  always_comb begin
    v1_d = v1_q;  a1_d = a1_q;  b1_d = b1_q;
    v2_d = v2_q;  sign_d = sign_q;
    nan_d = nan_q;  inf_d = inf_q;  zero_d = zero_q;
    exp_a_d = exp_a_q;  exp_b_d = exp_b_q;
    sig_a_d = sig_a_q;  sig_b_d = sig_b_q;
    if (adv1) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        a1_d = bus.FP_A;
        b1_d = bus.FP_B;
      end
    end
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        sign_d  = a1_q[31] ^ b1_q[31];
        nan_d   = prod_nan;
        inf_d   = (op_a.inf | op_b.inf) & ~prod_nan;
        zero_d  = (op_a.zero | op_b.zero) & ~prod_nan;
        exp_a_d = op_a.exp;
        exp_b_d = op_b.exp;
        sig_a_d = op_a.sig;
        sig_b_d = op_b.sig;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;  a1_q <= '0;  b1_q <= '0;
      v2_q <= 1'b0;  sign_q <= 1'b0;
      nan_q <= 1'b0;  inf_q <= 1'b0;  zero_q <= 1'b0;
      exp_a_q <= '0;  exp_b_q <= '0;  sig_a_q <= '0;  sig_b_q <= '0;
    end else begin
      v1_q <= v1_d;  a1_q <= a1_d;  b1_q <= b1_d;
      v2_q <= v2_d;  sign_q <= sign_d;
      nan_q <= nan_d;  inf_q <= inf_d;  zero_q <= zero_d;
      exp_a_q <= exp_a_d;  exp_b_q <= exp_b_d;
      sig_a_q <= sig_a_d;  sig_b_q <= sig_b_d;
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = v2_q;
  assign bus.SIGN_out  = sign_q;
  assign bus.EXP_A     = exp_a_q;
  assign bus.EXP_B     = exp_b_q;
  assign bus.SIG_A     = sig_a_q;
  assign bus.SIG_B     = sig_b_q;
  assign bus.isNaN     = nan_q;
  assign bus.isINF     = inf_q;
  assign bus.isZ_tab   = zero_q;
endmodule
`default_nettype wire

// File: tb/tb_fpmul_unpack.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_fpmul_unpack : directed scoreboard bench for fpmul_unpack            |
// | Revision        : 1.0                                                    |
// +-------------------------------------------------------------------------+
module tb_fpmul_unpack;
  typedef struct packed {
    logic        sign;
    logic [7:0]  ea;
    logic [23:0] sa;
    logic [7:0]  eb;
    logic [23:0] sb;
    logic        nan;
    logic        inf;
    logic        z;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  fpmul_unpack_if bus ();

  fpmul_unpack dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic s, input logic [7:0] ea, input logic [23:0] sa,
                              input logic [7:0] eb, input logic [23:0] sbv,
                              input logic n, input logic i, input logic z);
    exp_t e;
    e.sign = s; e.ea = ea; e.sa = sa; e.eb = eb; e.sb = sbv;
    e.nan = n; e.inf = i; e.z = z;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic compare_out(input string tag, input exp_t e);
    check({tag, ".sign"}, 32'(bus.SIGN_out), 32'(e.sign));
    check({tag, ".expa"}, 32'(bus.EXP_A), 32'(e.ea));
    check({tag, ".siga"}, 32'(bus.SIG_A), 32'(e.sa));
    check({tag, ".expb"}, 32'(bus.EXP_B), 32'(e.eb));
    check({tag, ".sigb"}, 32'(bus.SIG_B), 32'(e.sb));
    check({tag, ".nan"},  32'(bus.isNaN), 32'(e.nan));
    check({tag, ".inf"},  32'(bus.isINF), 32'(e.inf));
    check({tag, ".zero"}, 32'(bus.isZ_tab), 32'(e.z));
  endtask

  // Output-side scoreboard: every transfer pops the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      assert (sb_q.size() > 0)
      else begin
        errors++;
        $error("FAIL sb_underflow observed=output expected=none");
      end
      if (sb_q.size() > 0) compare_out("out", sb_q.pop_front());
    end
  end

  // Called with inputs changing just after a rising edge; returns likewise.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.FP_A     = a;
    bus.FP_B     = b;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready) sb_q.push_back(e);
    else check("send_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".drained"}, 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  exp_t e1, e_den;

  initial begin
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.FP_A      = '0;
    bus.FP_B      = '0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    compare_out("rst", mk(0, 8'h00, 24'h0, 8'h00, 24'h0, 0, 0, 0));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);

    // Normal product with two-cycle latency.
    e1 = mk(1, 8'h7F, 24'hC00000, 8'h80, 24'h800000, 0, 0, 0);
    send(32'h3FC00000, 32'hC0000000, e1);
    @(negedge clk);
    check("lat.stage1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat.stage2", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    wait_drain("normal");

    // Special-value classification, back to back at full throughput.
    send(32'h7F800000, 32'h00000000, mk(0, 8'hFF, 24'h800000, 8'h00, 24'h000000, 1, 0, 0));
    send(32'h7FC00000, 32'h3F800000, mk(0, 8'hFF, 24'hC00000, 8'h7F, 24'h800000, 1, 0, 0));
    send(32'hFF800000, 32'h40000000, mk(1, 8'hFF, 24'h800000, 8'h80, 24'h800000, 0, 1, 0));
    send(32'h80000000, 32'h3F800000, mk(1, 8'h00, 24'h000000, 8'h7F, 24'h800000, 0, 0, 1));
    send(32'h00000000, 32'hFF800000, mk(1, 8'h00, 24'h000000, 8'hFF, 24'h800000, 1, 0, 0));
    send(32'h7F800000, 32'h7F800000, mk(0, 8'hFF, 24'h800000, 8'hFF, 24'h800000, 0, 1, 0));
    send(32'h00000000, 32'h80000000, mk(1, 8'h00, 24'h000000, 8'h00, 24'h000000, 0, 0, 1));
`ifdef FPMUL_UNPACK_DENORM_EN
    e_den = mk(0, 8'h01, 24'h000001, 8'h7F, 24'h800000, 0, 0, 0);
`else
    e_den = mk(0, 8'h00, 24'h000000, 8'h7F, 24'h800000, 0, 0, 1);
`endif
    send(32'h00000001, 32'h3F800000, e_den);
    wait_drain("special");

    // Downstream stall: two accepts fill the pipe, then hold for 5 cycles.
    bus.out_ready = 1'b0;
    send(32'h3FC00000, 32'hC0000000, e1);
    send(32'h40400000, 32'h3F800000, mk(0, 8'h80, 24'hC00000, 8'h7F, 24'h800000, 0, 0, 0));
    bus.in_valid = 1'b1;
    bus.FP_A     = 32'h41000000;
    bus.FP_B     = 32'h41000000;
    @(negedge clk);
    check("stall.in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall.out_valid", 32'(bus.out_valid), 32'd1);
      if (sb_q.size() > 0) compare_out("hold", sb_q[0]);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain("stall");

    // Reset with both stages occupied.
    bus.out_ready = 1'b0;
    send(32'h3FC00000, 32'hC0000000, e1);
    send(32'h3FC00000, 32'hC0000000, e1);
    check("prerst.out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    compare_out("midrst", mk(0, 8'h00, 24'h0, 8'h00, 24'h0, 0, 0, 0));
    sb_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst.in_ready", 32'(bus.in_ready), 32'd1);
    check("postrst.out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    send(32'hFF800000, 32'h40000000, mk(1, 8'hFF, 24'h800000, 8'h80, 24'h800000, 0, 1, 0));
    wait_drain("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fpmul_unpack.md
FPMUL_UNPACK -- requirements
Module: fpmul_unpack

Interface
REQ-001 The port clk (input, 1) SHALL be the single rising-edge clock.
REQ-002 The port rst_n (input, 1) SHALL be the asynchronous, active-low reset.
REQ-003 The port in_valid (input, 1) SHALL mark an operand pair on FP_A/FP_B.
REQ-004 The port in_ready (output, 1) SHALL mean the block accepts the pair this cycle.
REQ-005 The ports FP_A and FP_B (input, 32 each) SHALL carry IEEE-754 single operands.
REQ-006 The port out_valid (output, 1) SHALL mark valid unpacked outputs.
REQ-007 The port out_ready (input, 1) SHALL mean the downstream multiply stage accepts outputs.
REQ-008 The port SIGN_out (output, 1) SHALL carry the product sign, sign(A) XOR sign(B).
REQ-009 The ports EXP_A and EXP_B (output, 8 each) SHALL carry the biased exponents.
REQ-010 The ports SIG_A and SIG_B (output, 24 each) SHALL carry the significands with the hidden bit prepended.
REQ-011 The ports isINF, isNaN and isZ_tab (output, 1 each) SHALL carry the product classification flags.

Function
REQ-012 Two-stage pipeline: S1 registers raw operands, S2 registers decoded fields and flags; each stage has a valid bit.
REQ-013 Latency SHALL be 2 cycles from accepted input to out_valid while out_ready=1, at throughput 1/cycle.
REQ-014 Handshake: transfer on valid&ready only; adv2 = ~v2 | out_ready; adv1 = ~v1 | adv2; in_ready = adv1 (combinational).
REQ-015 While out_valid=1 and out_ready=0, all outputs SHALL hold stable; no pair is dropped or duplicated; order is preserved.
REQ-016 Per operand: exp=0xFF with frac!=0 is NaN; exp=0xFF with frac=0 is INF; exp=0 with frac=0 is zero; otherwise normal, SIG={1,frac}.
REQ-017 isNaN SHALL be 1 if either operand is NaN, or one operand is INF and the other is zero.
REQ-018 isINF SHALL be 1 if either operand is INF and isNaN=0.
REQ-019 isZ_tab SHALL be 1 if either operand is zero and isNaN=0; at most one flag is set.
REQ-020 Simultaneous accept into S1 and S2-to-downstream transfer in one cycle SHALL be supported without a bubble.

Reset
REQ-021 On rst_n=0, v1, v2 and out_valid SHALL clear immediately; all data outputs and flags SHALL reset to 0.
REQ-022 In-flight pairs are discarded on reset mid-operation; in_ready SHALL be 1 from the first cycle after release.

Configuration
REQ-023 With FPMUL_UNPACK_DENORM_EN defined, a denormal (exp=0, frac!=0) SHALL output EXP=1, SIG={0,frac} and is not zero.
REQ-024 Without FPMUL_UNPACK_DENORM_EN, a denormal SHALL be flushed: EXP=0, SIG=0, treated as zero for REQ-017..019.

Structure
REQ-025 The shared package fpmul_pkg SHALL hold the widths (EXP_W=8, FRAC_W=23, SIG_W=24), EXP_MAX=8'hFF and EXP_BIAS=127.
REQ-026 The block SHALL instantiate one combinational sub-module, fpmul_classify, twice, once per operand (outputs isNaN/isINF/isZero/EXP/SIG).

Verification
REQ-027 The bench SHALL cover: 0x3FC00000 x 0xC0000000 -> after 2 cycles SIGN_out=1, EXP_A=0x7F, SIG_A=0xC00000, EXP_B=0x80, SIG_B=0x800000, flags all 0.
REQ-028 The bench SHALL cover: 0x7F800000 x 0x00000000 -> isNaN=1, isINF=0, isZ_tab=0; 0x7FC00000 x 0x3F800000 -> isNaN=1.
REQ-029 The bench SHALL cover: 0xFF800000 x 0x40000000 -> isINF=1, SIGN_out=1; 0x80000000 x 0x3F800000 -> isZ_tab=1, SIGN_out=1.
REQ-030 The bench SHALL cover: back-to-back pairs with out_ready=0 for 5 cycles -> in_ready falls after 2 accepts, outputs held, all pairs delivered in order.
REQ-031 The bench SHALL cover: 0x00000001 x 0x3F800000 -> with macro EXP_A=1, SIG_A=0x000001, isZ_tab=0; without macro isZ_tab=1, SIG_A=0.
REQ-032 The bench SHALL cover: rst_n asserted with both stages full -> out_valid=0 immediately, outputs 0, in_ready=1 after release.
